// File: rtl/program_ram_loader_if.sv
// Bus between the host-side UART receiver, the program loader and the
// program RAM write port / CPU reset. The loader uses the slave view; the
// host/RAM side (or a testbench) uses the master view.
interface program_ram_loader_if #(
  parameter int unsigned ADDR_WIDTH = 14
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  ram_wr_en;
  logic [ADDR_WIDTH-1:0] ram_wr_addr;
  logic [31:0]           ram_wr_data;
  logic                  cpu_reset_n;
  logic                  loading;
  logic                  done;
  logic                  error;

  modport master (
    output rx_data,
    output rx_valid,
    input  ram_wr_en,
    input  ram_wr_addr,
    input  ram_wr_data,
    input  cpu_reset_n,
    input  loading,
    input  done,
    input  error
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output ram_wr_en,
    output ram_wr_addr,
    output ram_wr_data,
    output cpu_reset_n,
    output loading,
    output done,
    output error
  );
endinterface

// File: rtl/program_ram_loader.sv
// Program RAM loader: parses a framed byte stream
// (MAGIC, CNT_LO, CNT_HI, CNT little-endian words, CSUM) and writes each
// word into the program RAM. The CPU is held in reset until a frame ends
// with a matching XOR checksum.
module program_ram_loader #(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter logic [7:0]  MAGIC      = 8'hA5
) (
  input  logic                clk,
  input  logic                reset_n,
  program_ram_loader_if.slave bus
);

  // Largest legal word count: the whole RAM.
  localparam logic [16:0] CAPACITY = 17'(2 ** ADDR_WIDTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CNT_LO = 3'd1,
    ST_CNT_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_RUN    = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

  // Running frame checksum: plain XOR of every byte between MAGIC and CSUM.
  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_t                r_state;
  logic [7:0]            r_csum;
  logic [7:0]            r_cnt_lo;
  logic [15:0]           r_remain;
  logic [1:0]            r_byte_idx;
  logic [23:0]           r_word;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [31:0]           r_wr_data;
  logic                  r_cpu_reset_n;
  logic                  r_loading;
  logic                  r_done;
  logic                  r_error;

  logic [15:0]           w_cnt;
  logic [31:0]           w_word;
  logic                  w_magic;
  logic                  w_cnt_too_big;

  // Full count once the high byte arrives; full word once the 4th byte arrives.
  assign w_cnt         = {bus.rx_data, r_cnt_lo};
  assign w_word        = {bus.rx_data, r_word};
  assign w_magic       = (bus.rx_data == MAGIC);
  assign w_cnt_too_big = ({1'b0, w_cnt} > CAPACITY);

  // Frame parser FSM; every output is a flop so cpu_reset_n cannot glitch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_csum        <= 8'h00;
      r_cnt_lo      <= 8'h00;
      r_remain      <= 16'h0000;
      r_byte_idx    <= 2'd0;
      r_word        <= 24'h000000;
      r_addr        <= '0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= 32'h0000_0000;
      r_cpu_reset_n <= 1'b0;
      r_loading     <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      // The write strobe lives for exactly one cycle.
      r_wr_en <= 1'b0;
      if (bus.rx_valid) begin
        case (r_state)
          ST_IDLE, ST_RUN, ST_ERROR: begin
            // Only MAGIC (re)starts a load; anything else is noise.
            if (w_magic) begin
              r_state       <= ST_CNT_LO;
              r_csum        <= 8'h00;
              r_addr        <= '0;
              r_done        <= 1'b0;
              r_error       <= 1'b0;
              r_loading     <= 1'b1;
              r_cpu_reset_n <= 1'b0;
            end
          end
          ST_CNT_LO: begin
            r_cnt_lo <= bus.rx_data;
            r_csum   <= csum_step(r_csum, bus.rx_data);
            r_state  <= ST_CNT_HI;
          end
          ST_CNT_HI: begin
            r_csum     <= csum_step(r_csum, bus.rx_data);
            r_remain   <= w_cnt;
            r_byte_idx <= 2'd0;
            if (w_cnt_too_big) begin
              // Frame would overrun the RAM: reject before any write.
              r_state   <= ST_ERROR;
              r_error   <= 1'b1;
              r_loading <= 1'b0;
            end else if (w_cnt == 16'h0000) begin
              r_state <= ST_CSUM;
            end else begin
              r_state <= ST_DATA;
            end
          end
          ST_DATA: begin
            r_csum     <= csum_step(r_csum, bus.rx_data);
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_addr;
              r_wr_data <= w_word;
              // Address may wrap to 0 after the last word; no write follows.
              r_addr    <= r_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
              r_remain  <= r_remain - 16'd1;
              if (r_remain == 16'd1) begin
                r_state <= ST_CSUM;
              end
            end else begin
              // Little-endian assembly: newest byte enters at the top.
              r_word <= {bus.rx_data, r_word[23:8]};
            end
          end
          ST_CSUM: begin
            r_loading <= 1'b0;
            if (bus.rx_data == r_csum) begin
              r_state       <= ST_RUN;
              r_done        <= 1'b1;
              r_cpu_reset_n <= 1'b1;
            end else begin
              r_state       <= ST_ERROR;
              r_error       <= 1'b1;
              r_cpu_reset_n <= 1'b0;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.ram_wr_en   = r_wr_en;
  assign bus.ram_wr_addr = r_wr_addr;
  assign bus.ram_wr_data = r_wr_data;
  assign bus.cpu_reset_n = r_cpu_reset_n;
  assign bus.loading     = r_loading;
  assign bus.done        = r_done;
  assign bus.error       = r_error;

endmodule

// File: tb/tb_program_ram_loader.sv
// Bench for program_ram_loader: frames are generated, a frame-level model
// predicts the RAM writes and final status, a scoreboard queue carries the
// expected writes (with the clock edge they must appear on) to a monitor.
module tb_program_ram_loader;
  localparam int         AW    = 14;
  localparam int         CAP   = 1 << AW;
  localparam logic [7:0] MAGIC = 8'hA5;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  program_ram_loader_if #(.ADDR_WIDTH(AW)) bus ();

  program_ram_loader #(.ADDR_WIDTH(AW), .MAGIC(MAGIC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct { int pos; int addr; logic [31:0] data; } pend_t;
  typedef struct { int addr; logic [31:0] data; int edge_n; } exp_t;

  pend_t      pend_q[$];
  exp_t       sb_q[$];
  logic [7:0] frame[$];
  int         edge_cnt = 0;
  int         checks   = 0;
  int         passed   = 0;
  bit         exp_done;
  bit         exp_error;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  // Monitor: count active edges, then inspect outputs 1 time unit later.
  initial begin
    forever begin
      @(posedge clk);
      edge_cnt++;
      #1;
      if (bus.ram_wr_en === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_write", bus.ram_wr_en, 1'b0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("wr_addr", bus.ram_wr_addr, e.addr);
          check("wr_data", bus.ram_wr_data, e.data);
          check("wr_edge", edge_cnt, e.edge_n);
        end
      end
    end
  end

  // Frame-level model: find MAGIC, read CNT, list the words and judge CSUM.
  task automatic build_expect(input logic [7:0] s[$]);
    int m;
    int cnt;
    logic [7:0] x;
    m = 0;
    while (m < s.size() && s[m] != MAGIC) m++;
    cnt = {s[m+2], s[m+1]};
    pend_q.delete();
    if (cnt > CAP) begin
      exp_done  = 1'b0;
      exp_error = 1'b1;
    end else begin
      x = 8'h00;
      for (int i = m + 1; i < m + 3 + 4 * cnt; i++) x ^= s[i];
      for (int w = 0; w < cnt; w++) begin
        pend_t p;
        p.pos  = m + 3 + 4 * w + 3;
        p.addr = w;
        p.data = {s[p.pos], s[p.pos-1], s[p.pos-2], s[p.pos-3]};
        pend_q.push_back(p);
      end
      exp_done  = (s[m + 3 + 4 * cnt] == x);
      exp_error = !exp_done;
    end
  endtask

  task automatic make_frame(input logic [31:0] words[$], input bit corrupt);
    int n;
    logic [7:0] x;
    n = words.size();
    frame.delete();
    frame.push_back(MAGIC);
    frame.push_back(n[7:0]);
    frame.push_back(n[15:8]);
    foreach (words[i]) begin
      logic [31:0] w;
      w = words[i];
      frame.push_back(w[7:0]);
      frame.push_back(w[15:8]);
      frame.push_back(w[23:16]);
      frame.push_back(w[31:24]);
    end
    x = 8'h00;
    for (int i = 1; i < frame.size(); i++) x ^= frame[i];
    frame.push_back(corrupt ? (x ^ 8'h01) : x);
  endtask

  task automatic rand_words(input int n, output logic [31:0] q[$]);
    q.delete();
    for (int i = 0; i < n; i++) begin
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(0, 3) == 0) w[15:8] = MAGIC;
      q.push_back(w);
    end
  endtask

  // Drive frame[first..last-1]; random idle gaps (with junk data) unless b2b.
  task automatic send_stream(input int first, input int last, input bit b2b);
    for (int i = first; i < last; i++) begin
      @(negedge clk);
      bus.rx_data  = frame[i];
      bus.rx_valid = 1'b1;
      if (pend_q.size() > 0 && pend_q[0].pos == i) begin
        pend_t p;
        exp_t  e;
        p = pend_q.pop_front();
        e.addr   = p.addr;
        e.data   = p.data;
        e.edge_n = edge_cnt + 1;
        sb_q.push_back(e);
      end
      if (!b2b) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          bus.rx_valid = 1'b0;
          bus.rx_data  = 8'($urandom);
        end
      end
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic check_status(input string tag);
    repeat (2) @(negedge clk);
    check({tag, "_done"},    bus.done,        exp_done);
    check({tag, "_error"},   bus.error,       exp_error);
    check({tag, "_cpu_rst"}, bus.cpu_reset_n, exp_done);
    check({tag, "_loading"}, bus.loading,     1'b0);
    check({tag, "_missing"}, sb_q.size(),     0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_wr_en"},   bus.ram_wr_en,   1'b0);
    check({tag, "_wr_addr"}, bus.ram_wr_addr, 0);
    check({tag, "_wr_data"}, bus.ram_wr_data, 0);
    check({tag, "_cpu_rst"}, bus.cpu_reset_n, 1'b0);
    check({tag, "_loading"}, bus.loading,     1'b0);
    check({tag, "_done"},    bus.done,        1'b0);
    check({tag, "_error"},   bus.error,       1'b0);
  endtask

  task automatic run_frame(input logic [31:0] words[$], input bit corrupt, input bit b2b, input string tag);
    make_frame(words, corrupt);
    build_expect(frame);
    send_stream(0, frame.size(), b2b);
    check_status(tag);
  endtask

  // Watchdog: a hung run still reports.
  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout required finish");
    $display("%0d/%0d checks passed", passed, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w[$];
    logic [7:0]  stray[$];
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Directed two-word frame, then corrupted checksum, then recovery.
    w = '{32'h12345678, 32'hDEADBEEF};
    run_frame(w, 1'b0, 1'b0, "good2");
    run_frame(w, 1'b1, 1'b0, "badcsum");
    run_frame(w, 1'b0, 1'b1, "recover");

    // Stray non-MAGIC bytes ahead of the frame, rx_valid held high.
    rand_words(3, w);
    make_frame(w, 1'b0);
    stray = '{8'h00, 8'hFF, 8'h13};
    frame = {stray, frame};
    build_expect(frame);
    send_stream(0, frame.size(), 1'b1);
    check_status("stray");

    // Empty frame.
    w.delete();
    run_frame(w, 1'b0, 1'b0, "cnt0");

    // Oversized count: rejected right after CNT_HI.
    frame = '{MAGIC, 8'h01, 8'h40};
    build_expect(frame);
    send_stream(0, frame.size(), 1'b1);
    check_status("cnt4001");

    // Reload after done: CPU reset drops the cycle after MAGIC.
    rand_words(2, w);
    run_frame(w, 1'b0, 1'b0, "pre_reload");
    rand_words(2, w);
    make_frame(w, 1'b0);
    build_expect(frame);
    send_stream(0, 1, 1'b1);
    check("reload_cpu_rst", bus.cpu_reset_n, 1'b0);
    check("reload_loading", bus.loading, 1'b1);
    check("reload_done", bus.done, 1'b0);
    send_stream(1, frame.size(), 1'b0);
    check_status("reload");

    // MAGIC-valued data bytes are plain data.
    w = '{32'hA5A5A5A5};
    run_frame(w, 1'b0, 1'b1, "magic_data");

    // Asynchronous reset in the middle of the second word.
    rand_words(3, w);
    make_frame(w, 1'b0);
    build_expect(frame);
    send_stream(0, 9, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("midreset");
    pend_q.delete();
    check("midreset_sb", sb_q.size(), 0);
    @(negedge clk);
    reset_n = 1'b1;
    rand_words(2, w);
    run_frame(w, 1'b0, 1'b0, "after_reset");

    // Randomised frames.
    for (int k = 0; k < 8; k++) begin
      rand_words($urandom_range(0, 5), w);
      make_frame(w, 1'($urandom_range(0, 1)));
      stray.delete();
      repeat ($urandom_range(0, 3)) begin
        logic [7:0] b;
        b = 8'($urandom);
        if (b == MAGIC) b = 8'h00;
        stray.push_back(b);
      end
      frame = {stray, frame};
      build_expect(frame);
      send_stream(0, frame.size(), 1'($urandom_range(0, 1)));
      check_status("random");
    end

    // Full-capacity frame: last write lands on the top address.
    rand_words(CAP, w);
    run_frame(w, 1'b0, 1'b1, "capacity");
    repeat (4) @(negedge clk);
    check("final_idle_wr_en", bus.ram_wr_en, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/program_ram_loader.md
Name: program_ram_loader

Overview:
- Writer side of the program memory interface: receives a framed byte stream from the host (UART receiver output) and writes 32-bit words into the program RAM write port.
- Holds the CPU in reset while loading; releases it after a frame completes with a good checksum.
- Sits in hw_top between the UART receiver and the program RAM/xenowing reset.

Parameters:
- ADDR_WIDTH, 14, word address width of the program RAM; capacity is 2**ADDR_WIDTH words.
- MAGIC, 8'hA5, frame start byte.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- rx_data  input  8  received byte; valid only when rx_valid=1.
- rx_valid  input  1  one-cycle strobe per received byte; no backpressure; may assert on consecutive cycles.
- ram_wr_en  output  1  one-cycle RAM write strobe.
- ram_wr_addr  output  ADDR_WIDTH  word address for the write.
- ram_wr_data  output  32  word to write.
- cpu_reset_n  output  1  active-low reset to xenowing; low while loading or failed.
- loading  output  1  high from MAGIC accepted until the frame ends.
- done  output  1  high after a good frame; cleared when the next MAGIC is accepted.
- error  output  1  high after a bad frame; cleared when the next MAGIC is accepted.

Behaviour:
- Reset values:
  - Outputs: ram_wr_en=0, ram_wr_addr=0, ram_wr_data=0, cpu_reset_n=0, loading=0, done=0, error=0.
  - State=IDLE.
- Frame format: MAGIC, CNT_LO, CNT_HI, then CNT words of 4 bytes each (little-endian, byte 0 = bits 7:0), then CSUM.
- CNT is 16-bit unsigned. CSUM is the XOR of every byte after MAGIC, excluding CSUM itself.
- All state changes occur only on cycles with rx_valid=1; when rx_valid=0 everything holds.
- State machine:
  - IDLE: MAGIC -> CNT_LO; clear checksum accumulator, word address, done and error; set loading=1 and cpu_reset_n=0. Any other byte is ignored.
  - CNT_LO: latch the low count byte -> CNT_HI.
  - CNT_HI: latch the high count byte.
    - If CNT > 2**ADDR_WIDTH -> ERROR immediately (no writes).
    - Else if CNT = 0 -> CSUM.
    - Else -> DATA with byte index 0.
  - DATA: shift the byte into the word assembly register.
    - On byte index 3, register ram_wr_data/ram_wr_addr and pulse ram_wr_en high for exactly the next cycle.
    - Then increment the word address and decrement the remaining count.
    - When the remaining count reaches 0 -> CSUM; otherwise stay in DATA with byte index 0.
  - CSUM: compare the byte with the accumulator.
    - Match -> RUN: done=1, cpu_reset_n=1.
    - Mismatch -> ERROR: error=1, cpu_reset_n stays 0.
    - loading=0 in both cases.
  - RUN: MAGIC starts a reload, behaving as in IDLE (cpu_reset_n drops to 0 the cycle after). Other bytes are ignored.
  - ERROR: same as RUN, but cpu_reset_n remains 0.
- Write latency: ram_wr_en is high in the cycle after the rx_valid cycle carrying the 4th byte. Back-to-back rx_valid still yields one write per 4 bytes with no loss.
- Address wrap: with CNT = 2**ADDR_WIDTH, the last write is to address 2**ADDR_WIDTH-1. The internal counter may wrap to 0 but no further write occurs.
- A MAGIC value appearing inside CNT/DATA/CSUM is treated as data, not as a restart.
- Partial writes from a failed frame stay in RAM; the CPU remains in reset.
- Async reset mid-frame: everything returns to reset values immediately. Any ram_wr_en pulse in flight is suppressed.
- cpu_reset_n is driven from a flop (glitch-free).

Test Plan:
- Reset, then send A5 02 00 | 78 56 34 12 | EF BE AD DE | CSUM=0x02^0x00^0x78^0x56^0x34^0x12^0xEF^0xBE^0xAD^0xDE.
  - Required response: two ram_wr_en pulses, addr 0 data 0x12345678 and addr 1 data 0xDEADBEEF.
  - Then done=1, cpu_reset_n=1, loading=0.
- Same frame with CSUM xor 0x01 -> both writes occur; error=1, done=0, cpu_reset_n=0. A following valid frame then gives done=1, error=0.
- Stray bytes 00 FF 13 before MAGIC, with rx_valid held high continuously -> stray bytes are ignored, and writes are one cycle after each 4th byte with no dropped words.
- A5 00 00 CSUM=00 -> no writes; done=1, cpu_reset_n=1. Count 0x4001 (ADDR_WIDTH=14) -> error=1 right after CNT_HI, no writes.
- After done, send A5 -> cpu_reset_n=0 and loading=1 on the next cycle; done clears. Assert reset_n=0 mid-DATA -> all outputs return to reset values at once, and the next write after reload is to addr 0.
- Frame with data byte 0xA5 inside a word (e.g. A5 01 00 A5 A5 A5 A5 CSUM) -> the word 0xA5A5A5A5 is written to addr 0, with no restart mid-frame.
